noc_switch: RTL and testbench

NOC_SWITCH -- requirements
Module: noc_switch

---
 rtl/noc_switch.sv | 176 +++++++++++++++++
 tb/tb_noc_switch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_switch.sv
// noc_switch: two-input (ring, local) wormhole ring switch with per-input FIFOs and round-robin output arbitration.
// Optional NOC_SWITCH_LOOPBACK_EN: local packets addressed to this node are delivered to the local output.
module noc_switch #(
    parameter int DATA_SIZE = 4,
    parameter int ADDR_SIZE = 1,
    parameter int ADDR      = 0,
    parameter int NODES_NUM = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic [DATA_SIZE-1:0] l_data_i,
    input  logic                 l_in_w,
    output logic                 l_out_r,
    output logic [DATA_SIZE-1:0] l_data_o,
    output logic                 l_out_w,
    input  logic                 l_in_r,
    input  logic [DATA_SIZE-1:0] r_data_i,
    input  logic                 r_in_w,
    output logic                 r_out_r,
    output logic [DATA_SIZE-1:0] r_data_o,
    output logic                 r_out_w,
    input  logic                 r_in_r
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [ADDR_SIZE-1:0] SELF = ADDR_SIZE'(ADDR % NODES_NUM);
    // Index 0 is the ring side and 1 the local side, for inputs and outputs alike.
    localparam int RING  = 0;
    localparam int LOCAL = 1;
`ifdef NOC_SWITCH_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [1:0] {PKT_IDLE, PKT_OPEN, PKT_DROP} pkt_state_t;

    logic [DATA_SIZE-1:0] w_in_data [2];
    logic [1:0]           w_in_w, w_dn_rdy;
    logic                 r_alive;
    pkt_state_t           r_pkt [2];
    pkt_state_t           w_pkt_nxt [2];
    logic [DATA_SIZE-1:0] r_mem [2][BUF_DEPTH];
    logic [PTR_W:0]       r_wptr [2];
    logic [PTR_W:0]       r_rptr [2];
    logic [1:0]           w_full, w_empty, w_ready, w_accept, w_push, w_pop, w_drop;
    logic [DATA_SIZE-1:0] w_head [2];
    logic [1:0]           w_head_out;
    logic [1:0]           w_req [2];
    logic [1:0]           r_lock_vld, r_lock_src, r_prio;
    logic [1:0]           w_own_vld, w_own, w_xfer;
    logic [DATA_SIZE-1:0] w_out_data [2];

    assign w_in_data[RING]  = r_data_i;
    assign w_in_data[LOCAL] = l_data_i;
    assign w_in_w           = {l_in_w, r_in_w};
    assign w_dn_rdy         = {l_in_r, r_in_r};

    assign r_out_r  = w_ready[RING];
    assign l_out_r  = w_ready[LOCAL];
    assign r_out_w  = w_own_vld[RING];
    assign l_out_w  = w_own_vld[LOCAL];
    assign r_data_o = w_out_data[RING];
    assign l_data_o = w_out_data[LOCAL];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_empty[i]    = (r_wptr[i] == r_rptr[i]);
            w_full[i]     = (r_wptr[i] == {~r_rptr[i][PTR_W], r_rptr[i][PTR_W-1:0]});
            w_ready[i]    = r_alive && !w_full[i];
            w_accept[i]   = w_in_w[i] && w_ready[i];
            w_head[i]     = r_mem[i][r_rptr[i][PTR_W-1:0]];
            w_head_out[i] = (w_head[i][ADDR_SIZE-1:0] == SELF) ? 1'(LOCAL) : 1'(RING);
            // Without loopback, local packets to this node are swallowed at the input.
            w_drop[i]     = (i == LOCAL) && !LOOPBACK && (w_in_data[i][ADDR_SIZE-1:0] == SELF);
        end
    end

    // Input packet tracking: decides which accepted flits enter the FIFO.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: every combinational output gets a default first so no latch can be inferred.
            w_pkt_nxt[i] = r_pkt[i];
            w_push[i]    = 1'b0;
            if (w_accept[i]) begin
                case (w_in_data[i][DATA_SIZE-1 -: 2])
                    FT_HEAD: begin
                        w_push[i]    = !w_drop[i];
                        w_pkt_nxt[i] = w_drop[i] ? PKT_DROP : PKT_OPEN;
                    end
                    FT_SINGLE: begin
                        w_push[i]    = !w_drop[i];
                        w_pkt_nxt[i] = PKT_IDLE;
                    end
                    FT_BODY: w_push[i] = (r_pkt[i] == PKT_OPEN);
                    default: begin
                        w_push[i]    = (r_pkt[i] == PKT_OPEN);
                        w_pkt_nxt[i] = PKT_IDLE;
                    end
                endcase
            end
        end
    end

    // Heads and singles request by address; body and tail follow their input's lock.
    always_comb begin
        w_pop = '0;
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 2; i++) begin
                if (w_head[i][DATA_SIZE-2])
                    w_req[o][i] = !w_empty[i] && (w_head_out[i] == 1'(o));
                else
                    w_req[o][i] = !w_empty[i] && r_lock_vld[o] && (r_lock_src[o] == 1'(i));
            end
            w_own[o]     = 1'b0;
            w_own_vld[o] = 1'b0;
            if (r_lock_vld[o]) begin
                w_own[o]     = r_lock_src[o];
                w_own_vld[o] = w_req[o][r_lock_src[o]];
            end else if (&w_req[o]) begin
                w_own[o]     = r_prio[o];
                w_own_vld[o] = 1'b1;
            end else if (w_req[o][RING]) begin
                w_own[o]     = 1'(RING);
                w_own_vld[o] = 1'b1;
            end else if (w_req[o][LOCAL]) begin
                w_own[o]     = 1'(LOCAL);
                w_own_vld[o] = 1'b1;
            end
            w_xfer[o]     = w_own_vld[o] && w_dn_rdy[o];
            w_out_data[o] = w_own_vld[o] ? w_head[w_own[o]] : '0;
            if (w_xfer[o]) w_pop[w_own[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_alive    <= 1'b0;
            r_lock_vld <= '0;
            r_lock_src <= '0;
            r_prio     <= {2{1'(RING)}};
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_pkt[i]  <= PKT_IDLE;
            end
        end else begin
            r_alive <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                r_pkt[i] <= w_pkt_nxt[i];
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + (PTR_W+1)'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + (PTR_W+1)'(1);
            end
            // Lock is taken at grant (not transfer) so a stalled head keeps its output.
            for (int o = 0; o < 2; o++) begin
                if (w_xfer[o] && w_out_data[o][DATA_SIZE-1]) begin
                    r_lock_vld[o] <= 1'b0;
                    r_prio[o]     <= ~w_own[o];
                end else if (w_own_vld[o]) begin
                    r_lock_vld[o] <= 1'b1;
                    r_lock_src[o] <= w_own[o];
                end
            end
        end
    end

    // NOTE: FIFO storage is not reset; pointers reset and unowned outputs are masked to zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (w_push[i]) r_mem[i][r_wptr[i][PTR_W-1:0]] <= w_in_data[i];
    end

endmodule

// File: tb/tb_noc_switch.sv
// tb_noc_switch: directed self-checking bench for noc_switch (ADDR=0, NODES_NUM=2, DATA_SIZE=4, BUF_DEPTH=4).
// Flit nibble: [3:2] type (01 head, 00 body, 10 tail, 11 single), [0] destination.
module tb_noc_switch;
    logic       clk = 1'b0;
    logic       a_rst = 1'b1;
    logic [3:0] l_data_i, l_data_o, r_data_i, r_data_o;
    logic       l_in_w, l_out_r, l_out_w, l_in_r;
    logic       r_in_w, r_out_r, r_out_w, r_in_r;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [3:0] r_q[$];
    logic [3:0] l_q[$];
    logic [3:0] exp_q[$];
    bit         r_w_seen;
    bit         l_r_low;

    noc_switch #(
        .DATA_SIZE(4), .ADDR_SIZE(1), .ADDR(0), .NODES_NUM(2), .BUF_DEPTH(4)
    ) dut (
        .clk(clk), .a_rst(a_rst),
        .l_data_i(l_data_i), .l_in_w(l_in_w), .l_out_r(l_out_r),
        .l_data_o(l_data_o), .l_out_w(l_out_w), .l_in_r(l_in_r),
        .r_data_i(r_data_i), .r_in_w(r_in_w), .r_out_r(r_out_r),
        .r_data_o(r_data_o), .r_out_w(r_out_w), .r_in_r(r_in_r)
    );

    always #5 clk = ~clk;

    // Record every output transfer; inputs only change just after a rising edge.
    always @(negedge clk) begin
        if (r_out_w && r_in_r) r_q.push_back(r_data_o);
        if (l_out_w && l_in_r) l_q.push_back(l_data_o);
        if (r_out_w) r_w_seen = 1'b1;
        if (a_rst && !l_out_r) l_r_low = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input bit use_l);
        logic [3:0] q[$];
        if (use_l) q = l_q;
        else       q = r_q;
        check({tag, "_count"}, q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            check($sformatf("%s_%0d", tag, i), q[i], exp_q[i]);
    endtask

    // Start just after a rising edge; hold strobe until the switch has taken the flit.
    task automatic send(input bit side_l, input logic [3:0] f);
        int  n = 0;
        logic rdy;
        if (side_l) begin l_data_i = f; l_in_w = 1'b1; end
        else        begin r_data_i = f; r_in_w = 1'b1; end
        @(negedge clk);
        rdy = side_l ? l_out_r : r_out_r;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = side_l ? l_out_r : r_out_r;
            n++;
        end
        if (!rdy) check(side_l ? "send_l_timeout" : "send_r_timeout", rdy, 1);
        @(posedge clk);
        #1;
        if (side_l) l_in_w = 1'b0;
        else        r_in_w = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        r_q.delete();
        l_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        l_data_i = '0; r_data_i = '0; l_in_w = 0; r_in_w = 0; l_in_r = 1; r_in_r = 1;
        #2 a_rst = 1'b0;

        // Reset with random inputs: every output is zero.
        repeat (4) begin
            @(posedge clk); #1;
            l_data_i = 4'($urandom); r_data_i = 4'($urandom);
            l_in_w = 1'($urandom); r_in_w = 1'($urandom);
            l_in_r = 1'($urandom); r_in_r = 1'($urandom);
            @(negedge clk);
            check("rst_outputs", {l_out_r, r_out_r, l_out_w, r_out_w, l_data_o, r_data_o}, 0);
        end
        l_data_i = '0; r_data_i = '0; l_in_w = 0; r_in_w = 0; l_in_r = 1; r_in_r = 1;
        a_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", {l_out_r, r_out_r}, 2'b11);
        idle(1);
        clear_q();

        // Local head(dest 1), body, tail to the ring; head is presented one edge after acceptance.
        l_data_i = 4'h5; l_in_w = 1'b1;
        @(posedge clk); #1;
        l_in_w = 1'b0;
        check("lat_r_out_w", r_out_w, 1);
        check("lat_r_data_o", r_data_o, 4'h5);
        check("lat_l_out_w", l_out_w, 0);
        send(1, 4'h2);
        send(1, 4'h8);
        idle(8);
        exp_q = {4'h5, 4'h2, 4'h8};
        check_q("fwd", 0);
        clear_q();

        // Ring single to this node goes to the local output only.
        r_w_seen = 1'b0;
        send(0, 4'hC);
        idle(6);
        exp_q = {4'hC};
        check_q("eject", 1);
        check("eject_r_out_w", r_w_seen, 0);
        clear_q();

        // Backpressure: 6 flits against a 4-deep FIFO with the ring output stalled.
        r_in_r = 1'b0;
        fork
            begin
                send(1, 4'h5); send(1, 4'h0); send(1, 4'h1);
                send(1, 4'h2); send(1, 4'h3); send(1, 4'h9);
            end
            begin
                idle(6);
                check("bp_l_out_r", l_out_r, 0);
                check("bp_r_out_w", r_out_w, 1);
                check("bp_r_data_o", r_data_o, 4'h5);
                r_in_r = 1'b1;
            end
        join
        idle(10);
        exp_q = {4'h5, 4'h0, 4'h1, 4'h2, 4'h3, 4'h9};
        check_q("bp", 0);
        clear_q();

        // Contention for the ring output: ring wins, packets never interleave.
        fork
            begin send(0, 4'h5); send(0, 4'h2); send(0, 4'hA); end
            begin send(1, 4'h7); send(1, 4'h3); send(1, 4'hB); end
        join
        idle(10);
        exp_q = {4'h5, 4'h2, 4'hA, 4'h7, 4'h3, 4'hB};
        check_q("arb", 0);
        clear_q();

        // Round robin: after a ring packet ends, the local input wins the next tie.
        send(0, 4'hD);
        idle(4);
        exp_q = {4'hD};
        check_q("rr_solo", 0);
        clear_q();
        fork
            send(0, 4'hF);
            send(1, 4'hD);
        join
        idle(6);
        exp_q = {4'hD, 4'hF};
        check_q("rr_tie", 0);
        clear_q();

        // Stray body and tail with no open packet are discarded.
        send(1, 4'h2);
        send(1, 4'h8);
        send(1, 4'hD);
        idle(6);
        exp_q = {4'hD};
        check_q("stray", 0);
        check("stray_l_out", l_q.size(), 0);
        clear_q();

        // Local packet addressed to this node.
        l_r_low = 1'b0;
        send(1, 4'h4);
        send(1, 4'h1);
        send(1, 4'h8);
        idle(6);
`ifdef NOC_SWITCH_LOOPBACK_EN
        exp_q = {4'h4, 4'h1, 4'h8};
`endif
        check_q("loop", 1);
        check("loop_r_out", r_q.size(), 0);
        check("loop_l_out_r_low", l_r_low, 0);
        clear_q();

        // Reset mid-packet aborts it; trailing body/tail afterwards are discarded.
        r_in_r = 1'b0;
        send(1, 4'h5);
        send(1, 4'h2);
        check("mid_r_out_w", r_out_w, 1);
        a_rst = 1'b0;
        #1;
        check("mid_rst_outputs", {l_out_r, r_out_r, l_out_w, r_out_w, l_data_o, r_data_o}, 0);
        @(posedge clk);
        @(negedge clk);
        clear_q();
        a_rst = 1'b1;
        r_in_r = 1'b1;
        idle(1);
        send(1, 4'h1);
        send(1, 4'h9);
        send(1, 4'hD);
        idle(6);
        exp_q = {4'hD};
        check_q("abort", 0);
        clear_q();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
